wall_map: RTL and testbench
===========================

Name: wall_map

Overview:
- Owns the game-field wall bitmap of 64 x 44 grid cells.
- Serves the display stage's per-grid wall lookups (request_x/request_y -> is_wall) with fixed one-cycle latency.
- Serves a second read port to game logic for tank/shell collision checks.
- Buffers wall-hit events from game logic and applies them only at the frame boundary, so one rendered frame never shows a partially updated map.

Parameters:
- MAP_W, 64, grid columns (x range 0..63)
- MAP_H, 44, game grid rows (y range 0..43)
- HIT_DEPTH, 4, hit FIFO entries (power of two)

Ports:
- clk  in  1  system clock (same clock as the display stage)
- rst_n  in  1  asynchronous active-low reset
- i_restart  in  1  one-cycle pulse: rebuild the default map
- i_buzy  in  1  display busy flag; low for exactly one cycle per frame (frame-boundary pulse)
- i_request_x  in  6  display lookup column
- i_request_y  in  6  display lookup row
- o_is_wall  out  1  wall bit for the previous cycle's display request
- i_query_x  in  6  game-logic lookup column
- i_query_y  in  6  game-logic lookup row
- o_query_wall  out  1  wall bit for the previous cycle's query
- i_hit_valid  in  1  hit event offered
- i_hit_x  in  6  hit column
- i_hit_y  in  6  hit row
- o_hit_ready  out  1  FIFO can accept; a transfer occurs when valid && ready
- o_init_done  out  1  map valid, RUN state

Behaviour:
- Reset values: all outputs 0; FSM = INIT; init index = 0; FIFO empty.
- FSM states: INIT, RUN, DRAIN.
- INIT:
  - Writes one cell per cycle, linear index y*64+x, from 0 to 2815 (2816 cycles).
  - Default layout: wall if x==0 || x==63 || y==0 || y==43 (border), or x[3:0]==8 && y[2:0]==3 (pillar).
  - Read ports return 0 during INIT; o_hit_ready = 0; o_init_done = 0.
  - After index 2815 is written, go to RUN; o_init_done = 1 from the next cycle.
- RUN:
  - Both read ports are registered: output at cycle t+1 reflects the map for the address presented at cycle t.
  - Any y >= 44 reads as 0.
  - FIFO accepts hits whenever it is not full.
  - When i_buzy == 0 and the FIFO is non-empty, go to DRAIN.
- DRAIN:
  - Pops and applies one hit per cycle; returns to RUN the cycle after the FIFO empties.
  - Pushes remain allowed during DRAIN.
  - Entries pushed during DRAIN are drained in the same pass.
  - Simultaneous push and pop on a full FIFO is accepted; occupancy is unchanged.
- Hit application:
  - Border cell: hit discarded, map unchanged.
  - Empty cell: discarded.
  - Out-of-range (y >= 44): discarded.
  - Pillar cell: cleared (see optional feature for hit points).
- Read/write ordering: a read of a cell in the same cycle it is written returns the old value; the new value is visible from the next cycle.
- FIFO full: o_hit_ready = 0; the upstream holds valid and data stable until accepted.
- i_restart:
  - Accepted in any state and takes priority over everything else.
  - Flushes the FIFO, clears the init index, enters INIT next cycle, deasserts o_init_done.
- Async reset mid-operation: identical effect to i_restart, but immediate.
- i_buzy low while in INIT: ignored.

Optional Feature:
- Macro: WALL_MAP_HP_EN.
- Defined:
  - Each pillar cell carries 2-bit hit points, set to 3 by INIT.
  - A hit decrements HP; the wall clears when HP reaches 0.
  - Reads report wall while HP != 0.
  - Border cells carry no HP.
- Undefined:
  - No HP storage.
  - The first hit on a pillar clears it.

Test Plan:
- Reset release, then wait 2816 cycles -> o_init_done rises at cycle 2817. Read (0,5) -> 1, (8,3) -> 1, (9,3) -> 0, (5,50) -> 0, each one cycle after the request.
- Push hit (8,3) with i_buzy = 1 -> (8,3) still reads 1. Pulse i_buzy low -> reads 0 two cycles after the pulse. With WALL_MAP_HP_EN, three hit+pulse rounds are needed.
- Push 4 hits without a boundary pulse -> o_hit_ready = 0 after the 4th. A 5th offered hit is held. After one boundary pulse -> all 5 applied, FIFO empty, state RUN.
- Hit on border (0,0) and on empty cell (9,3), then pulse -> both cells unchanged, FIFO empties in 2 cycles.
- Pulse i_restart mid-DRAIN with 3 entries queued -> FIFO empty, o_init_done = 0, and after 2816 cycles the previously cleared pillar (8,3) reads 1 again.
- Query port and request port on the same address during a drain write to it -> both return the old value that cycle and the new value the next cycle.

Source files
------------

// File: rtl/wall_map_if.sv
// Display lookup, game-logic query and hit-event signals shared between wall_map and its clients.
interface wall_map_if;
  logic [5:0] i_request_x;
  logic [5:0] i_request_y;
  logic       o_is_wall;
  logic [5:0] i_query_x;
  logic [5:0] i_query_y;
  logic       o_query_wall;
  logic       i_hit_valid;
  logic [5:0] i_hit_x;
  logic [5:0] i_hit_y;
  logic       o_hit_ready;

  modport master (
    output i_request_x, i_request_y, i_query_x, i_query_y,
    output i_hit_valid, i_hit_x, i_hit_y,
    input  o_is_wall, o_query_wall, o_hit_ready
  );

  modport slave (
    input  i_request_x, i_request_y, i_query_x, i_query_y,
    input  i_hit_valid, i_hit_x, i_hit_y,
    output o_is_wall, o_query_wall, o_hit_ready
  );
endinterface

// File: rtl/wall_map.sv
// Game-field wall bitmap with two registered read ports and frame-synchronous hit application.
// Optional macro WALL_MAP_HP_EN gives pillars 2-bit hit points instead of single-hit removal.
module wall_map #(
  parameter int MAP_W     = 64,
  parameter int MAP_H     = 44,
  parameter int HIT_DEPTH = 4
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      i_restart,
  input  logic      i_buzy,
  output logic      o_init_done,
  wall_map_if.slave bus
);

  localparam int CELLS = MAP_W * MAP_H;
  localparam int IDX_W = $clog2(CELLS);
  localparam int PTR_W = $clog2(HIT_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [5:0] X_LAST  = 6'(MAP_W - 1);
  localparam logic [5:0] Y_LAST  = 6'(MAP_H - 1);
  localparam logic [5:0] Y_LIMIT = 6'(MAP_H);
`ifdef WALL_MAP_HP_EN
  localparam int CELL_W = 2;
`else
  localparam int CELL_W = 1;
`endif

  typedef enum logic [1:0] {ST_INIT, ST_RUN, ST_DRAIN} state_t;

  state_t state_q, state_d;

  logic [CELL_W-1:0] cell_mem [CELLS];

  logic [5:0]       init_x, init_y;
  logic             init_last;
  logic             init_done_q;

  logic [5:0]       fifo_x [HIT_DEPTH];
  logic [5:0]       fifo_y [HIT_DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count, count_next;
  logic             fifo_full, fifo_empty;
  logic             hit_ready, push, pop;

  logic [5:0]        head_x, head_y;
  logic [CELL_W-1:0] head_cell;
  logic              hit_apply;

  logic is_wall_q, query_wall_q;

  function automatic logic [IDX_W-1:0] cell_idx(input logic [5:0] x, input logic [5:0] y);
    return IDX_W'(32'(y) * MAP_W + 32'(x));
  endfunction

  function automatic logic is_border(input logic [5:0] x, input logic [5:0] y);
    return (x == 6'd0) || (x == X_LAST) || (y == 6'd0) || (y == Y_LAST);
  endfunction

  function automatic logic is_pillar(input logic [5:0] x, input logic [5:0] y);
    return (x[3:0] == 4'd8) && (y[2:0] == 3'd3);
  endfunction

  // Rows at or beyond MAP_H do not exist and always read as open floor.
  function automatic logic lookup(input logic [5:0] x, input logic [5:0] y);
    return (y < Y_LIMIT) ? (cell_mem[cell_idx(x, y)] != '0) : 1'b0;
  endfunction

  assign init_last  = (init_x == X_LAST) && (init_y == Y_LAST);
  assign fifo_full  = (count == CNT_W'(HIT_DEPTH));
  assign fifo_empty = (count == '0);

  // A full FIFO still accepts during DRAIN because the same edge pops an entry.
  assign hit_ready  = (state_q != ST_INIT) && (!fifo_full || (state_q == ST_DRAIN));
  assign push       = bus.i_hit_valid && hit_ready;
  assign pop        = (state_q == ST_DRAIN) && !fifo_empty;
  assign count_next = count + CNT_W'(push) - CNT_W'(pop);

  assign head_x    = fifo_x[rd_ptr];
  assign head_y    = fifo_y[rd_ptr];
  assign head_cell = (head_y < Y_LIMIT) ? cell_mem[cell_idx(head_x, head_y)] : '0;
  assign hit_apply = pop && (head_y < Y_LIMIT) && !is_border(head_x, head_y) && (head_cell != '0);

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_INIT:  if (init_last) state_d = ST_RUN;
      ST_RUN:   if (!i_buzy && !fifo_empty) state_d = ST_DRAIN;
      ST_DRAIN: if (count_next == '0) state_d = ST_RUN;
      default:  state_d = ST_INIT;
    endcase
    if (i_restart) state_d = ST_INIT;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_INIT;
      init_x      <= '0;
      init_y      <= '0;
      init_done_q <= 1'b0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
    end else if (i_restart) begin
      state_q     <= ST_INIT;
      init_x      <= '0;
      init_y      <= '0;
      init_done_q <= 1'b0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
    end else begin
      state_q     <= state_d;
      init_done_q <= (state_d != ST_INIT);
      if (state_q == ST_INIT) begin
        if (init_x == X_LAST) begin
          init_x <= '0;
          init_y <= init_last ? 6'd0 : init_y + 6'd1;
        end else begin
          init_x <= init_x + 6'd1;
        end
      end
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count_next;
    end
  end

  // Single write port: INIT sweep or one drained hit; a restart cycle writes nothing.
  always_ff @(posedge clk) begin
    if (!i_restart) begin
      if (state_q == ST_INIT) begin
        cell_mem[cell_idx(init_x, init_y)] <=
          (is_border(init_x, init_y) || is_pillar(init_x, init_y)) ? '1 : '0;
      end else if (hit_apply) begin
        cell_mem[cell_idx(head_x, head_y)] <= head_cell - CELL_W'(1);
      end
      if (push) begin
        fifo_x[wr_ptr] <= bus.i_hit_x;
        fifo_y[wr_ptr] <= bus.i_hit_y;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      is_wall_q    <= 1'b0;
      query_wall_q <= 1'b0;
    end else begin
      is_wall_q    <= (state_q != ST_INIT) && !i_restart && lookup(bus.i_request_x, bus.i_request_y);
      query_wall_q <= (state_q != ST_INIT) && !i_restart && lookup(bus.i_query_x, bus.i_query_y);
    end
  end

  assign bus.o_is_wall    = is_wall_q;
  assign bus.o_query_wall = query_wall_q;
  assign bus.o_hit_ready  = hit_ready;
  assign o_init_done      = init_done_q;

endmodule

// File: tb/tb_wall_map.sv
// Randomized self-checking bench for wall_map against a cell/hit-point reference map.
module tb_wall_map;

`ifdef WALL_MAP_HP_EN
  localparam int PILLAR_HP = 3;
`else
  localparam int PILLAR_HP = 1;
`endif
  localparam int INIT_CYCLES = 64 * 44;

  typedef struct {
    int x;
    int y;
  } hit_t;

  logic clk = 1'b0;
  logic rst_n;
  logic restart;
  logic buzy;
  logic init_done;

  int   ref_hp [44][64];
  hit_t pending [$];
  int   num_compared = 0;
  int   num_mismatched = 0;

  wall_map_if bus();

  wall_map dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_restart  (restart),
    .i_buzy     (buzy),
    .o_init_done(init_done),
    .bus        (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic bit ref_border(input int x, input int y);
    return (x == 0) || (x == 63) || (y == 0) || (y == 43);
  endfunction

  function automatic void model_init();
    for (int y = 0; y < 44; y++)
      for (int x = 0; x < 64; x++) begin
        if (ref_border(x, y))                         ref_hp[y][x] = 99;
        else if ((x % 16 == 8) && (y % 8 == 3))       ref_hp[y][x] = PILLAR_HP;
        else                                          ref_hp[y][x] = 0;
      end
  endfunction

  function automatic int model_wall(input int x, input int y);
    if (y >= 44) return 0;
    return (ref_hp[y][x] != 0) ? 1 : 0;
  endfunction

  function automatic void model_apply();
    foreach (pending[i]) begin
      if (pending[i].y < 44 && !ref_border(pending[i].x, pending[i].y) &&
          ref_hp[pending[i].y][pending[i].x] != 0)
        ref_hp[pending[i].y][pending[i].x]--;
    end
    pending.delete();
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input int got, input int exp);
    num_compared++;
    if (got != exp) begin
      num_mismatched++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input int rx, input int ry, input int qx, input int qy);
    bus.i_request_x = 6'(rx);
    bus.i_request_y = 6'(ry);
    bus.i_query_x   = 6'(qx);
    bus.i_query_y   = 6'(qy);
  endtask

  task automatic readCheck(input string tag, input int rx, input int ry, input int qx, input int qy);
    applyStimulus(rx, ry, qx, qy);
    tick();
    checkOutput({tag, "_is_wall"}, int'(bus.o_is_wall), model_wall(rx, ry));
    checkOutput({tag, "_query"}, int'(bus.o_query_wall), model_wall(qx, qy));
  endtask

  task automatic pushHit(input int x, input int y);
    bit   accepted = 0;
    hit_t h;
    bus.i_hit_valid = 1'b1;
    bus.i_hit_x     = 6'(x);
    bus.i_hit_y     = 6'(y);
    for (int i = 0; i < 50; i++) begin
      if (bus.o_hit_ready) begin
        tick();
        accepted = 1;
        break;
      end
      tick();
    end
    bus.i_hit_valid = 1'b0;
    if (!accepted) checkOutput("push_timeout", 0, 1);
    else begin
      h.x = x;
      h.y = y;
      pending.push_back(h);
    end
  endtask

  task automatic frameBoundary();
    buzy = 1'b0;
    tick();
    buzy = 1'b1;
    repeat (12) tick();
    model_apply();
  endtask

  task automatic randomHit(output int x, output int y);
    case ($urandom_range(0, 3))
      0, 3: begin
        x = 8 + 16 * int'($urandom_range(0, 3));
        y = 3 + 8 * int'($urandom_range(0, 4));
      end
      1: begin
        x = ($urandom_range(0, 1) == 0) ? 0 : 63;
        y = int'($urandom_range(0, 43));
      end
      default: begin
        x = int'($urandom_range(0, 63));
        y = int'($urandom_range(0, 47));
      end
    endcase
  endtask

  initial begin
    int   hx, hy, old_wall;
    hit_t h;

    rst_n = 1'b0;
    restart = 1'b0;
    buzy = 1'b1;
    bus.i_hit_valid = 1'b0;
    bus.i_hit_x = '0;
    bus.i_hit_y = '0;
    applyStimulus(8, 3, 0, 0);
    repeat (3) tick();
    checkOutput("rst_is_wall", int'(bus.o_is_wall), 0);
    checkOutput("rst_query", int'(bus.o_query_wall), 0);
    checkOutput("rst_ready", int'(bus.o_hit_ready), 0);
    checkOutput("rst_init_done", int'(init_done), 0);

    rst_n = 1'b1;
    model_init();
    repeat (INIT_CYCLES - 1) tick();
    checkOutput("init_done_early", int'(init_done), 0);
    checkOutput("init_ready", int'(bus.o_hit_ready), 0);
    checkOutput("init_read", int'(bus.o_is_wall), 0);
    tick();
    checkOutput("init_done_rise", int'(init_done), 1);
    checkOutput("run_ready", int'(bus.o_hit_ready), 1);

    readCheck("rd_a", 0, 5, 8, 3);
    readCheck("rd_b", 9, 3, 5, 50);
    readCheck("rd_c", 8, 3, 0, 5);

    // Repeated hits on (8,3), watching the drain write land against a held read address.
    for (int r = 0; r < PILLAR_HP; r++) begin
      pushHit(8, 3);
      readCheck("pending_hit", 8, 3, 8, 3);
      old_wall = model_wall(8, 3);
      buzy = 1'b0;
      tick();
      buzy = 1'b1;
      tick();
      checkOutput("write_cycle_req", int'(bus.o_is_wall), old_wall);
      checkOutput("write_cycle_qry", int'(bus.o_query_wall), old_wall);
      model_apply();
      tick();
      checkOutput("after_write_req", int'(bus.o_is_wall), model_wall(8, 3));
      checkOutput("after_write_qry", int'(bus.o_query_wall), model_wall(8, 3));
      repeat (4) tick();
    end
    readCheck("pillar_gone", 8, 3, 24, 3);

    pushHit(24, 3);
    pushHit(40, 3);
    pushHit(56, 3);
    pushHit(8, 11);
    checkOutput("ready_full", int'(bus.o_hit_ready), 0);
    bus.i_hit_valid = 1'b1;
    bus.i_hit_x = 6'd24;
    bus.i_hit_y = 6'd11;
    tick();
    checkOutput("ready_held", int'(bus.o_hit_ready), 0);
    buzy = 1'b0;
    tick();
    buzy = 1'b1;
    checkOutput("ready_drain_full", int'(bus.o_hit_ready), 1);
    tick();
    bus.i_hit_valid = 1'b0;
    h.x = 24;
    h.y = 11;
    pending.push_back(h);
    repeat (10) tick();
    model_apply();
    readCheck("full_a", 24, 3, 40, 3);
    readCheck("full_b", 56, 3, 8, 11);
    readCheck("full_c", 24, 11, 8, 3);
    checkOutput("ready_after_drain", int'(bus.o_hit_ready), 1);

    pushHit(0, 0);
    pushHit(9, 3);
    frameBoundary();
    readCheck("discard", 0, 0, 9, 3);

    pushHit(40, 11);
    pushHit(56, 11);
    pushHit(8, 19);
    pushHit(24, 19);
    buzy = 1'b0;
    tick();
    buzy = 1'b1;
    tick();
    restart = 1'b1;
    tick();
    restart = 1'b0;
    pending.delete();
    model_init();
    checkOutput("restart_init_done", int'(init_done), 0);
    checkOutput("restart_ready", int'(bus.o_hit_ready), 0);
    applyStimulus(0, 5, 0, 0);
    tick();
    checkOutput("restart_read_req", int'(bus.o_is_wall), 0);
    checkOutput("restart_read_qry", int'(bus.o_query_wall), 0);
    repeat (INIT_CYCLES - 2) tick();
    checkOutput("reinit_early", int'(init_done), 0);
    tick();
    checkOutput("reinit_done", int'(init_done), 1);
    readCheck("reinit_pillar", 8, 3, 0, 43);
    frameBoundary();
    readCheck("flushed_a", 40, 11, 56, 11);
    readCheck("flushed_b", 8, 19, 24, 19);

    for (int round = 0; round < 8; round++) begin
      int n = int'($urandom_range(1, 4));
      for (int k = 0; k < n; k++) begin
        randomHit(hx, hy);
        pushHit(hx, hy);
      end
      frameBoundary();
      for (int k = 0; k < 12; k++)
        readCheck("rand", int'($urandom_range(0, 63)), int'($urandom_range(0, 47)),
                  int'($urandom_range(0, 63)), int'($urandom_range(0, 47)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", num_compared, num_mismatched);
    $finish;
  end

endmodule
